// File: rtl/clk_div_phase_monitor.sv
// Samples a divided clock in the fast domain, measures its period and high time,
// emits a phase strobe per rising edge and tracks lock with a sticky error flag.
module clk_div_phase_monitor #(
  parameter int DIVIDER    = 4,
  parameter int LOCK_COUNT = 16,
  parameter int CNT_W      = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Div_Clk_In,
  input  logic             Enable,
  input  logic             Err_Clear,
  output logic             Strobe,
  output logic             Locked,
  output logic             Error,
  output logic [CNT_W-1:0] Period_Count,
  output logic [CNT_W-1:0] High_Count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    COUNT   = 2'd2,
    LOCKED  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] DIV_C   = CNT_W'(DIVIDER);
  localparam logic [CNT_W-1:0] TMO_C   = CNT_W'(2 * DIVIDER);
  localparam logic [CNT_W-1:0] HI_LO_C = CNT_W'(DIVIDER / 2);
  localparam logic [CNT_W-1:0] HI_HI_C = CNT_W'((DIVIDER + 1) / 2);
  localparam logic [7:0]       LOCK_C  = 8'(LOCK_COUNT);

  state_e           state_q;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             meas_valid_q, meas_valid_d;
  logic [7:0]       good_q;
  logic             strobe_q, locked_q, error_q;

  logic rise, fall, active, evaluate, period_ok, good_evt, bad_evt;

  assign rise      = s2_q & ~s3_q;
  assign fall      = ~s2_q & s3_q;
  assign active    = Enable && (state_q != IDLE);
  assign evaluate  = active && meas_valid_q;
  assign period_ok = (pcnt_q == DIV_C) && ((high_q == HI_LO_C) || (high_q == HI_HI_C));
  assign good_evt  = evaluate && rise && period_ok;
  // A stall is seen exactly once: pcnt passes through 2*DIVIDER on its way to saturation.
  assign bad_evt   = evaluate && ((rise && !period_ok) || (!rise && (pcnt_q == TMO_C)));

  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= Div_Clk_In;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // NOTE: every next-state variable gets a default first, so no latch can be inferred.
  always_comb begin
    pcnt_d       = pcnt_q;
    hcnt_d       = hcnt_q;
    period_d     = period_q;
    high_d       = high_q;
    meas_valid_d = meas_valid_q;
    if (!active) begin
      pcnt_d       = '0;
      hcnt_d       = '0;
      meas_valid_d = 1'b0;
    end else if (rise) begin
      pcnt_d       = CNT_W'(1);
      hcnt_d       = CNT_W'(1);
      meas_valid_d = 1'b1;
      if (meas_valid_q) period_d = pcnt_q;
    end else begin
      if (pcnt_q != CNT_MAX) pcnt_d = pcnt_q + 1'b1;
      if (s2_q && (hcnt_q != CNT_MAX)) hcnt_d = hcnt_q + 1'b1;
      if (fall && meas_valid_q) high_d = hcnt_q;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pcnt_q       <= '0;
      hcnt_q       <= '0;
      period_q     <= '0;
      high_q       <= '0;
      meas_valid_q <= 1'b0;
    end else begin
      pcnt_q       <= pcnt_d;
      hcnt_q       <= hcnt_d;
      period_q     <= period_d;
      high_q       <= high_d;
      meas_valid_q <= meas_valid_d;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      good_q   <= '0;
      strobe_q <= 1'b0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      if (!Enable) begin
        state_q  <= IDLE;
        good_q   <= '0;
        strobe_q <= 1'b0;
        locked_q <= 1'b0;
      end else begin
        strobe_q <= (state_q != IDLE) && rise;
        case (state_q)
          IDLE:    state_q <= ACQUIRE;
          ACQUIRE: if (rise) state_q <= COUNT;
          COUNT: begin
            if (good_evt) begin
              good_q <= good_q + 8'd1;
              if (good_q + 8'd1 == LOCK_C) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end else if (bad_evt) begin
              good_q <= '0;
            end
          end
          LOCKED: begin
            if (bad_evt) begin
              state_q  <= COUNT;
              locked_q <= 1'b0;
              good_q   <= '0;
            end
          end
        endcase
      end
      // A loss of lock in the same cycle as a clear request must not be lost.
      if (Enable && (state_q == LOCKED) && bad_evt) error_q <= 1'b1;
      else if (Err_Clear)                           error_q <= 1'b0;
    end
  end

  assign Strobe       = strobe_q;
  assign Locked       = locked_q;
  assign Error        = error_q;
  assign Period_Count = period_q;
  assign High_Count   = high_q;

endmodule

// File: tb/tb_clk_div_phase_monitor.sv
// Bench for clk_div_phase_monitor: two instances (div-by-4 and div-by-5) checked every
// cycle against a timestamp-based model of edges, periods, high times and lock state.
module tb_clk_div_phase_monitor;

  localparam int D0 = 4, LC0 = 16, D1 = 5, LC1 = 3;

  logic       clk, rst, enable, err_clear, div0, div1;
  logic       strobe0, locked0, error0, strobe1, locked1, error1;
  logic [7:0] per0, high0, per1, high1;

  clk_div_phase_monitor #(.DIVIDER(D0), .LOCK_COUNT(LC0), .CNT_W(8)) u_dut0 (
    .Clock(clk), .Reset(rst), .Div_Clk_In(div0), .Enable(enable), .Err_Clear(err_clear),
    .Strobe(strobe0), .Locked(locked0), .Error(error0),
    .Period_Count(per0), .High_Count(high0)
  );

  clk_div_phase_monitor #(.DIVIDER(D1), .LOCK_COUNT(LC1), .CNT_W(8)) u_dut1 (
    .Clock(clk), .Reset(rst), .Div_Clk_In(div1), .Enable(enable), .Err_Clear(err_clear),
    .Strobe(strobe1), .Locked(locked1), .Error(error1),
    .Period_Count(per1), .High_Count(high1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;

  // Reference model state, per instance.
  bit hist [2][3];
  bit m_active [2], m_ref [2], m_locked [2], m_error [2], m_strobe [2];
  int m_per [2], m_high [2], m_good [2], m_last [2];
  int mode [2];
  bit q0 [$];
  bit q1 [$];

  function automatic int div_of(input int i);
    return (i == 0) ? D0 : D1;
  endfunction

  function automatic int lock_of(input int i);
    return (i == 0) ? LC0 : LC1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 3; j++) hist[i][j] = 1'b0;
      m_active[i] = 0; m_ref[i] = 0; m_locked[i] = 0; m_error[i] = 0; m_strobe[i] = 0;
      m_per[i] = 0; m_high[i] = 0; m_good[i] = 0; m_last[i] = 0;
    end
  endtask

  // Sampled input reaches the edge detector two edges late; period and high time are
  // the number of edges since the last acted-on rising edge.
  task automatic model_edge(input int i, input bit din, input bit en, input bit clr);
    int d, lc, age;
    bit rise, fall, bad, good, set_err;
    d = div_of(i);
    lc = lock_of(i);
    rise = hist[i][1] && !hist[i][2];
    fall = !hist[i][1] && hist[i][2];
    age = edge_n - m_last[i];
    if (age > 255) age = 255;
    bad = 0; good = 0; set_err = 0;
    if (!en) begin
      m_active[i] = 0; m_ref[i] = 0; m_locked[i] = 0; m_good[i] = 0; m_strobe[i] = 0;
    end else if (!m_active[i]) begin
      m_active[i] = 1;
      m_strobe[i] = 0;
    end else begin
      m_strobe[i] = rise;
      if (m_ref[i]) begin
        if (rise) begin
          m_per[i] = age;
          if (age == d && (m_high[i] == d / 2 || m_high[i] == (d + 1) / 2)) good = 1;
          else bad = 1;
        end else if (age == 2 * d) begin
          bad = 1;
        end
        if (fall) m_high[i] = age;
        if (good && !m_locked[i]) begin
          m_good[i]++;
          if (m_good[i] == lc) m_locked[i] = 1;
        end
        if (bad) begin
          m_good[i] = 0;
          if (m_locked[i]) begin
            m_locked[i] = 0;
            set_err = 1;
          end
        end
      end
      if (rise) begin
        m_ref[i] = 1;
        m_last[i] = edge_n;
      end
    end
    if (set_err) m_error[i] = 1;
    else if (clr) m_error[i] = 0;
    hist[i][2] = hist[i][1];
    hist[i][1] = hist[i][0];
    hist[i][0] = din;
  endtask

  task automatic push_wave(input int i, input int hi, input int lo);
    for (int n = 0; n < hi + lo; n++) begin
      if (i == 0) q0.push_back(n < hi);
      else        q1.push_back(n < hi);
    end
  endtask

  task automatic refill(input int i);
    int d, r, len, hi;
    d = div_of(i);
    len = d;
    hi = int'($urandom_range(d / 2, (d + 1) / 2));
    if (mode[i] == 1) begin
      r = int'($urandom_range(0, 99));
      if (r >= 75 && r < 83) begin
        len = ($urandom_range(0, 1) == 1) ? d + 1 : d - 1;
        hi = len / 2;
      end else if (r >= 83 && r < 90) begin
        hi = 1;
      end else if (r >= 90 && r < 95) begin
        hi = d / 2;
        len = d + int'($urandom_range(d, 3 * d));
      end else if (r >= 95) begin
        hi = int'($urandom_range(d, 2 * d));
        len = hi + d / 2;
      end
    end
    push_wave(i, hi, len - hi);
  endtask

  task automatic pop_bit(input int i, output bit b);
    if (i == 0) begin
      if (q0.size() == 0) refill(0);
      b = q0.pop_front();
    end else begin
      if (q1.size() == 0) refill(1);
      b = q1.pop_front();
    end
  endtask

  task automatic check_all();
    check($sformatf("strobe0@%0d", edge_n), strobe0, m_strobe[0]);
    check($sformatf("locked0@%0d", edge_n), locked0, m_locked[0]);
    check($sformatf("error0@%0d", edge_n), error0, m_error[0]);
    check($sformatf("period0@%0d", edge_n), per0, m_per[0]);
    check($sformatf("high0@%0d", edge_n), high0, m_high[0]);
    check($sformatf("strobe1@%0d", edge_n), strobe1, m_strobe[1]);
    check($sformatf("locked1@%0d", edge_n), locked1, m_locked[1]);
    check($sformatf("error1@%0d", edge_n), error1, m_error[1]);
    check($sformatf("period1@%0d", edge_n), per1, m_per[1]);
    check($sformatf("high1@%0d", edge_n), high1, m_high[1]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strobe0"}, strobe0, 0);
    check({tag, "_locked0"}, locked0, 0);
    check({tag, "_error0"}, error0, 0);
    check({tag, "_period0"}, per0, 0);
    check({tag, "_high0"}, high0, 0);
    check({tag, "_strobe1"}, strobe1, 0);
    check({tag, "_locked1"}, locked1, 0);
    check({tag, "_error1"}, error1, 0);
    check({tag, "_period1"}, per1, 0);
    check({tag, "_high1"}, high1, 0);
  endtask

  task automatic step(input bit en, input bit clr);
    bit b0, b1;
    pop_bit(0, b0);
    pop_bit(1, b1);
    div0 = b0;
    div1 = b1;
    enable = en;
    err_clear = clr;
    @(posedge clk);
    edge_n++;
    model_edge(0, b0, en, clr);
    model_edge(1, b1, en, clr);
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0);
  endtask

  task automatic drain(input int i);
    while (((i == 0) ? q0.size() : q1.size()) > 0) step(1'b1, 1'b0);
  endtask

  initial begin
    int off_cnt;
    bit en_r, clr_r;
    rst = 1'b1; enable = 1'b0; err_clear = 1'b0; div0 = 1'b0; div1 = 1'b0;
    mode[0] = 0; mode[1] = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Ideal waveforms: both instances lock with clean measurements.
    run(100);
    check("p1_locked0", locked0, 1);
    check("p1_period0", per0, 4);
    check("p1_high0", high0, 2);
    check("p1_error0", error0, 0);
    check("p1_locked1", locked1, 1);

    // Dead divider on instance 0: timeout drops lock once, then relock with Error held.
    drain(0);
    push_wave(0, 0, 3 * D0);
    drain(0);
    check("stall_locked0", locked0, 0);
    check("stall_error0", error0, 1);
    run(90);
    check("relock_locked0", locked0, 1);
    check("relock_error0", error0, 1);

    // One stretched 5-cycle period.
    drain(0);
    push_wave(0, 2, 3);
    drain(0);
    run(3);
    check("stretch_period0", per0, 5);
    check("stretch_locked0", locked0, 0);
    check("stretch_error0", error0, 1);
    run(90);
    check("relock2_locked0", locked0, 1);

    // Bad period evaluated in the same cycle as Err_Clear: set wins.
    drain(0);
    push_wave(0, 1, 3);
    drain(0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("collide_error0", error0, 1);
    check("collide_locked0", locked0, 0);
    run(3);
    step(1'b1, 1'b1);
    check("clear_error0", error0, 0);

    // Odd divider: 1-cycle high time is a bad period.
    run(30);
    drain(1);
    push_wave(1, 1, 4);
    drain(1);
    run(3);
    check("odd_bad_locked1", locked1, 0);
    check("odd_bad_error1", error1, 1);
    run(40);
    check("odd_relock1", locked1, 1);

    // Randomized waveforms with random clears and enable drops.
    mode[0] = 1; mode[1] = 1;
    off_cnt = 0;
    for (int k = 0; k < 1500; k++) begin
      if (off_cnt == 0 && $urandom_range(0, 99) == 0) off_cnt = int'($urandom_range(1, 5));
      en_r = (off_cnt == 0);
      if (off_cnt > 0) off_cnt--;
      clr_r = ($urandom_range(0, 99) < 3);
      step(en_r, clr_r);
    end
    mode[0] = 0; mode[1] = 0;

    // Enable dropped mid-COUNT: Locked/Strobe clear, measurements held.
    repeat (3) step(1'b0, 1'b0);
    run(30);
    step(1'b0, 1'b0);
    check("dis_locked0", locked0, 0);
    check("dis_strobe0", strobe0, 0);
    check("dis_period0", per0, 4);
    repeat (5) step(1'b0, 1'b0);
    check("dis_hold_period0", per0, 4);
    check("dis_hold_high0", high0, 2);
    run(100);
    check("reen_locked0", locked0, 1);

    // Asynchronous reset while locked.
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(100);
    check("post_rst_locked0", locked0, 1);
    check("post_rst_error0", error0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
